multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle RV32 main control unit, the sequential successor to the single-cycle `control` decoder. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the same datapath strobes as before (`branch`, `mem_read`, `mem_to_reg`, `alu_op`, `mem_write`, `alu_src`, `reg_write`), plus `pc_write`, `ir_write` and `jump`. It also handles a variable-latency memory through a `mem_ready` handshake with a parametrised timeout, and adds optional I-ALU/LUI/JAL opcodes.

## Interface
Parameters:
- `EXT_OPS`, 1: 1 enables I-ALU (0010011), LUI (0110111) and JAL (1101111); 0 limits support to R (0110011), load (0000011), store (0100011) and branch (1100011).
- `TIMEOUT`, 16: consecutive `mem_ready`-low cycles before fault; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 7: opcode field from the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC register load enable.
- `ir_write` out 1: instruction register load enable.
- `branch` out 1: conditional PC update, gated by the datapath on zero.
- `jump` out 1: unconditional PC load from the ALU target.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `mem_to_reg` out 1: writeback source is memory data.
- `alu_op` out 2: 00 add, 01 sub, 10 funct decode, 11 pass B.
- `alu_src` out 1: ALU B operand is the immediate.
- `reg_write` out 1: register file write enable.
- `illegal` out 1: sticky, set on an unsupported opcode.
- `fault` out 1: sticky, set on a memory timeout.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Outputs are combinational from `state` and the latched opcode `op_q`. Any output not listed for a state is 0.
- FETCH:
  - `mem_read`=1.
  - On `mem_ready`=1: `ir_write`=1 and `pc_write`=1 (PC+4) in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: `op_q` <= `instruction`. An unsupported opcode sets `illegal` and goes to TRAP; otherwise go to EXECUTE.
- EXECUTE, by opcode:
  - R: `alu_op`=10, `alu_src`=0, then WB.
  - I-ALU: `alu_op`=10, `alu_src`=1, then WB.
  - LUI: `alu_op`=11, `alu_src`=1, then WB.
  - load/store: `alu_op`=00, `alu_src`=1, then MEM.
  - branch: `alu_op`=01, `alu_src`=0, `branch`=1, then FETCH.
  - JAL: `jump`=1, `alu_op`=00, then WB.
- MEM:
  - `mem_read`=1 for a load, `mem_write`=1 for a store; held until `mem_ready`.
  - Load then goes to WB; store then goes to FETCH.
- WB: `reg_write`=1, and `mem_to_reg`=1 for a load only. Then FETCH.
- TRAP: all strobes 0. Stay until `rst`.
- Timeout:
  - The wait counter (width $clog2(TIMEOUT+1)) increments each FETCH/MEM cycle with `mem_ready`=0.
  - It clears on `mem_ready`=1 and on any state change.
  - When the counter reaches TIMEOUT-1 and `mem_ready`=0, set `fault`; the next state is TRAP.
  - `mem_ready`=1 in that same cycle wins over the timeout.
- `mem_ready` is ignored outside FETCH and MEM.

## Timing
- Reset:
  - While `rst`=1, all outputs are 0.
  - On the first cycle after release, `state`=FETCH, `op_q`=0, counter=0, `illegal`=`fault`=0.
- Reset mid-instruction aborts the instruction; there is no partial writeback after reset.
- Cycles per instruction with zero-wait memory:
  - branch: 3
  - store, R, I-ALU, LUI, JAL: 4
  - load: 5
- Each `mem_ready`-low cycle in FETCH or MEM adds 1 cycle.
- `instruction` must be stable in DECODE; it is don't-care elsewhere.
- Strobes are single-cycle except the FETCH/MEM requests, which are held across waits.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams (OP_R, OP_LOAD, OP_STORE, OP_BRANCH, OP_IALU, OP_LUI, OP_JAL);
  - `alu_op` codes ALU_ADD/ALU_SUB/ALU_FUNCT/ALU_PASSB;
  - the 3-bit state encoding.
- One sub-module, `mem_wait_timer`: the counter plus timeout compare, with inputs `clk`, `rst`, `active`, `ready` and output `expired`. The FSM and output decode stay in the top module.

## Test plan
- R-type (0110011), `mem_ready` tied 1 -> states FETCH,DECODE,EXECUTE,WB; `alu_op`=10 in EXECUTE; `reg_write`=1 in cycle 4 only; back in FETCH on cycle 5.
- Load (0000011), memory ready 2 cycles late in MEM -> `mem_read` high 3 MEM cycles; WB with `mem_to_reg`=1; 7 cycles total.
- Store (0100011) then branch (1100011) -> `mem_write`=1 in MEM, no `reg_write`; branch asserts `branch`=1, `alu_op`=01 in EXECUTE; no WB.
- EXT_OPS=0, opcode 0110111 -> `illegal`=1 after DECODE; TRAP holds all strobes 0 for 20 cycles; `rst` pulse returns to FETCH with `illegal`=0.
- TIMEOUT=4, `mem_ready`=0 in FETCH -> `fault`=1 and TRAP after the 4th wait cycle. Repeat with `mem_ready`=1 on the 4th cycle -> DECODE, no fault.
- `rst` asserted in MEM of a store -> `mem_write` drops to 0 during reset; FETCH with `mem_read`=1 on the first cycle after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALU op codes and state encoding for multicycle_control
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  // The extended opcodes are only legal when the build enables them.
  function automatic logic op_supported(input logic [6:0] op, input logic ext);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH: ok = 1'b1;
      OP_IALU, OP_LUI, OP_JAL:            ok = ext;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts consecutive not-ready memory cycles and flags a timeout
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Leaving the waiting state or completing the access restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!active || ready) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A ready in the final allowed cycle still completes the access.
  assign expired = (TIMEOUT > 0) && active && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32 main control FSM with memory handshake timeout
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] instruction,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       branch,
  output logic       jump,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic       illegal,
  output logic       fault
);

  state_t     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic       fault_q, fault_d;
  logic       wait_active;
  logic       wait_expired;

  assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .active (wait_active),
    .ready  (mem_ready),
    .expired(wait_expired)
  );

  // State, latched opcode and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state selection; ready always takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        op_d = instruction;
        if (op_supported(instruction, EXT_OPS != 0)) begin
          state_d = ST_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end
      ST_EXECUTE: begin
        case (op_q)
          OP_LOAD, OP_STORE:           state_d = ST_MEM;
          OP_R, OP_IALU, OP_LUI, OP_JAL: state_d = ST_WB;
          default:                     state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          fault_d = 1'b1;
          state_d = ST_TRAP;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath strobes from state and latched opcode; forced low while in reset.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        ST_EXECUTE: begin
          case (op_q)
            OP_R: begin
              alu_op = ALU_FUNCT;
            end
            OP_IALU: begin
              alu_op  = ALU_FUNCT;
              alu_src = 1'b1;
            end
            OP_LUI: begin
              alu_op  = ALU_PASSB;
              alu_src = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              alu_op  = ALU_ADD;
              alu_src = 1'b1;
            end
            OP_BRANCH: begin
              alu_op = ALU_SUB;
              branch = 1'b1;
            end
            OP_JAL: begin
              alu_op = ALU_ADD;
              jump   = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_read  = (op_q == OP_LOAD);
          mem_write = (op_q == OP_STORE);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LOAD);
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q & ~rst;
  assign fault   = fault_q & ~rst;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam int T_A = 4;
  localparam int T_B = 16;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_IA = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  // Observation vector: {pcw, irw, br, jp, mr, mw, m2r, aop[1:0], asrc, rw, ill, flt}
  localparam logic [12:0] V_PCW  = 13'd1 << 12;
  localparam logic [12:0] V_IRW  = 13'd1 << 11;
  localparam logic [12:0] V_BR   = 13'd1 << 10;
  localparam logic [12:0] V_JP   = 13'd1 << 9;
  localparam logic [12:0] V_MR   = 13'd1 << 8;
  localparam logic [12:0] V_MW   = 13'd1 << 7;
  localparam logic [12:0] V_M2R  = 13'd1 << 6;
  localparam logic [12:0] V_ASRC = 13'd1 << 3;
  localparam logic [12:0] V_RW   = 13'd1 << 2;
  localparam logic [12:0] V_ILL  = 13'd1 << 1;
  localparam logic [12:0] V_FLT  = 13'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] instruction = '0;
  logic       mem_ready = 1'b0;

  logic pc_write_a, ir_write_a, branch_a, jump_a, mem_read_a, mem_write_a, mem_to_reg_a;
  logic alu_src_a, reg_write_a, illegal_a, fault_a;
  logic [1:0] alu_op_a;
  logic pc_write_b, ir_write_b, branch_b, jump_b, mem_read_b, mem_write_b, mem_to_reg_b;
  logic alu_src_b, reg_write_b, illegal_b, fault_b;
  logic [1:0] alu_op_b;

  logic [12:0] obs_a, obs_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.EXT_OPS(1), .TIMEOUT(T_A)) dut_a (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .ir_write(ir_write_a), .branch(branch_a), .jump(jump_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_to_reg(mem_to_reg_a),
    .alu_op(alu_op_a), .alu_src(alu_src_a), .reg_write(reg_write_a),
    .illegal(illegal_a), .fault(fault_a)
  );

  multicycle_control #(.EXT_OPS(0), .TIMEOUT(T_B)) dut_b (
    .clk(clk), .rst(rst), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(pc_write_b), .ir_write(ir_write_b), .branch(branch_b), .jump(jump_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b),
    .alu_op(alu_op_b), .alu_src(alu_src_b), .reg_write(reg_write_b),
    .illegal(illegal_b), .fault(fault_b)
  );

  assign obs_a = {pc_write_a, ir_write_a, branch_a, jump_a, mem_read_a, mem_write_a,
                  mem_to_reg_a, alu_op_a, alu_src_a, reg_write_a, illegal_a, fault_a};
  assign obs_b = {pc_write_b, ir_write_b, branch_b, jump_b, mem_read_b, mem_write_b,
                  mem_to_reg_b, alu_op_b, alu_src_b, reg_write_b, illegal_b, fault_b};

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] aluv(input int code);
    return 13'(code) << 4;
  endfunction

  function automatic bit supported(input logic [6:0] op, input bit ext);
    if (op == OPC_R || op == OPC_LD || op == OPC_ST || op == OPC_BR) return 1'b1;
    if (op == OPC_IA || op == OPC_LUI || op == OPC_JAL) return ext;
    return 1'b0;
  endfunction

  function automatic logic [12:0] exec_vec(input logic [6:0] op);
    if (op == OPC_R)   return aluv(2);
    if (op == OPC_IA)  return aluv(2) | V_ASRC;
    if (op == OPC_LUI) return aluv(3) | V_ASRC;
    if (op == OPC_LD || op == OPC_ST) return aluv(0) | V_ASRC;
    if (op == OPC_BR)  return aluv(1) | V_BR;
    return V_JP | aluv(0);
  endfunction

  // First cycle index at which a controller sits in its trap, or -1 if it never traps.
  function automatic int trap_index(input logic [6:0] op, input int wf, input int wm,
                                    input bit ext, input int tmo, output logic [12:0] tv);
    tv = '0;
    if (tmo > 0 && wf >= tmo) begin
      tv = V_FLT;
      return tmo;
    end
    if (!supported(op, ext)) begin
      tv = V_ILL;
      return wf + 2;
    end
    if (tmo > 0 && (op == OPC_LD || op == OPC_ST) && wm >= tmo) begin
      tv = V_FLT;
      return wf + 3 + tmo;
    end
    return -1;
  endfunction

  task automatic reset_pulse();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      instruction = 7'($urandom);
      mem_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("reset_a[%0d]", i), obs_a, '0);
      check($sformatf("reset_b[%0d]", i), obs_b, '0);
    end
  endtask

  // Run one instruction: wf fetch waits, wm memory waits; cut>=0 aborts by reset after cut cycles.
  task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input int cut, input int hold);
    logic [12:0] tl[$];
    bit          rdy[$];
    logic [12:0] tv_a, tv_b, exp_a, exp_b, mem_v;
    int          ta, tb, n;
    for (int i = 0; i < wf; i++) begin
      tl.push_back(V_MR);
      rdy.push_back(1'b0);
    end
    tl.push_back(V_MR | V_IRW | V_PCW);
    rdy.push_back(1'b1);
    tl.push_back('0);
    rdy.push_back(1'($urandom));
    if (supported(op, 1'b1)) begin
      tl.push_back(exec_vec(op));
      rdy.push_back(1'($urandom));
      if (op == OPC_LD || op == OPC_ST) begin
        mem_v = (op == OPC_LD) ? V_MR : V_MW;
        for (int j = 0; j <= wm; j++) begin
          tl.push_back(mem_v);
          rdy.push_back(j == wm);
        end
      end
      if (op != OPC_ST && op != OPC_BR) begin
        tl.push_back((op == OPC_LD) ? (V_RW | V_M2R) : V_RW);
        rdy.push_back(1'($urandom));
      end
    end
    ta = trap_index(op, wf, wm, 1'b1, T_A, tv_a);
    tb = trap_index(op, wf, wm, 1'b0, T_B, tv_b);
    n = (cut >= 0) ? cut : tl.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      instruction = (i == wf + 1) ? op : 7'($urandom);
      mem_ready = rdy[i];
      @(negedge clk);
      exp_a = (ta >= 0 && i >= ta) ? tv_a : tl[i];
      exp_b = (tb >= 0 && i >= tb) ? tv_b : tl[i];
      check($sformatf("op%b_a[%0d]", op, i), obs_a, exp_a);
      check($sformatf("op%b_b[%0d]", op, i), obs_b, exp_b);
    end
    if (cut < 0 && (ta >= 0 || tb >= 0)) begin
      for (int j = 0; j < hold; j++) begin
        @(posedge clk);
        #1;
        instruction = 7'($urandom);
        mem_ready = 1'b0;
        @(negedge clk);
        exp_a = (ta >= 0) ? tv_a : ((j < T_A) ? V_MR : V_FLT);
        exp_b = (tb >= 0) ? tv_b : ((j < T_B) ? V_MR : V_FLT);
        check($sformatf("hold_a[%0d]", j), obs_a, exp_a);
        check($sformatf("hold_b[%0d]", j), obs_b, exp_b);
      end
    end
    if (cut >= 0 || ta >= 0 || tb >= 0) reset_pulse();
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [6:0] op;
    int         sel, wf, wm;
    ops = '{OPC_R, OPC_LD, OPC_ST, OPC_BR, OPC_IA, OPC_LUI, OPC_JAL};

    reset_pulse();

    run_instr(OPC_R, 0, 0, -1, 3);
    run_instr(OPC_LD, 0, 2, -1, 3);
    run_instr(OPC_ST, 0, 0, -1, 3);
    run_instr(OPC_BR, 0, 0, -1, 3);
    run_instr(OPC_LUI, 0, 0, -1, 20);
    run_instr(OPC_R, 4, 0, -1, 3);
    run_instr(OPC_R, 3, 0, -1, 3);
    run_instr(OPC_ST, 0, 2, 4, 0);
    run_instr(OPC_ST, 0, 0, -1, 3);
    run_instr(OPC_LD, 0, 17, -1, 3);
    run_instr(OPC_ST, 1, 4, -1, 3);
    run_instr(OPC_JAL, 0, 0, -1, 3);

    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 8);
      op = (sel < 7) ? ops[sel] : 7'($urandom);
      wf = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      wm = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3);
      run_instr(op, wf, wm, -1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
